// File: rtl/id_exe_reg.sv
// id_exe_reg: ID/EX pipeline register feeding the ALU.
//
// Captures decoded operands and controls once per cycle, with stall (hold)
// and flush (store a bubble; flush wins over stall). When the macro
// ID_EXE_FORWARDING_EN is defined, MEM/WB results are forwarded onto the
// ALU operands and store data combinationally (MEM beats WB), and a stalled
// entry refreshes its operands with the forwarded values on every edge so a
// value whose producer retires during the stall is kept.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   stall, flush          pipeline control
//   id_*                  decode-stage instruction fields
//   mem_wb_en/dest/result MEM-stage producer
//   wb_wb_en/dest/value   WB-stage producer
//   exe_*                 registered instruction presented to EX

`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef EXE_CMD_LEN
`define EXE_CMD_LEN 4
`endif

module id_exe_reg #(
    parameter int unsigned WORD_LEN     = `WORD_LEN,
    parameter int unsigned EXE_CMD_LEN  = `EXE_CMD_LEN,
    parameter int unsigned REG_ADDR_LEN = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    id_valid,
    input  logic [WORD_LEN-1:0]     id_val1,
    input  logic [WORD_LEN-1:0]     id_val2,
    input  logic [WORD_LEN-1:0]     id_st_val,
    input  logic [WORD_LEN-1:0]     id_imm,
    input  logic                    id_use_imm,
    input  logic [REG_ADDR_LEN-1:0] id_rs1,
    input  logic [REG_ADDR_LEN-1:0] id_rs2,
    input  logic [REG_ADDR_LEN-1:0] id_dest,
    input  logic [EXE_CMD_LEN-1:0]  id_exe_cmd,
    input  logic                    id_wb_en,
    input  logic                    id_mem_r,
    input  logic                    id_mem_w,
    input  logic                    mem_wb_en,
    input  logic [REG_ADDR_LEN-1:0] mem_dest,
    input  logic [WORD_LEN-1:0]     mem_result,
    input  logic                    wb_wb_en,
    input  logic [REG_ADDR_LEN-1:0] wb_dest,
    input  logic [WORD_LEN-1:0]     wb_value,
    output logic                    exe_valid,
    output logic                    exe_wb_en,
    output logic                    exe_mem_r,
    output logic                    exe_mem_w,
    output logic [WORD_LEN-1:0]     exe_val1,
    output logic [WORD_LEN-1:0]     exe_val2,
    output logic [WORD_LEN-1:0]     exe_st_val,
    output logic [EXE_CMD_LEN-1:0]  exe_cmd,
    output logic [REG_ADDR_LEN-1:0] exe_dest
);

    logic                    valid_q, wb_en_q, mem_r_q, mem_w_q, use_imm_q;
    logic [WORD_LEN-1:0]     val1_q, val2_q, st_val_q;
    logic [REG_ADDR_LEN-1:0] rs1_q, rs2_q, dest_q;
    logic [EXE_CMD_LEN-1:0]  cmd_q;

    logic [WORD_LEN-1:0]     fwd_val1, fwd_val2, fwd_st_val;

`ifdef ID_EXE_FORWARDING_EN
    logic mem_hit1, mem_hit2, wb_hit1, wb_hit2;

    always_comb begin
        mem_hit1 = mem_wb_en && (mem_dest == rs1_q) && (rs1_q != '0);
        mem_hit2 = mem_wb_en && (mem_dest == rs2_q) && (rs2_q != '0);
        wb_hit1  = wb_wb_en  && (wb_dest  == rs1_q) && (rs1_q != '0);
        wb_hit2  = wb_wb_en  && (wb_dest  == rs2_q) && (rs2_q != '0);

        fwd_val1 = val1_q;
        if (mem_hit1)     fwd_val1 = mem_result;
        else if (wb_hit1) fwd_val1 = wb_value;

        fwd_st_val = st_val_q;
        if (mem_hit2)     fwd_st_val = mem_result;
        else if (wb_hit2) fwd_st_val = wb_value;

        // An immediate operand never depends on rs2.
        fwd_val2 = val2_q;
        if (!use_imm_q) begin
            if (mem_hit2)     fwd_val2 = mem_result;
            else if (wb_hit2) fwd_val2 = wb_value;
        end
    end
`else
    assign fwd_val1   = val1_q;
    assign fwd_val2   = val2_q;
    assign fwd_st_val = st_val_q;

    // Producer inputs and source registers have no consumer in this build.
    logic unused_fwd;
    assign unused_fwd = ^{mem_wb_en, mem_dest, mem_result, wb_wb_en, wb_dest, wb_value,
                          rs1_q, rs2_q, use_imm_q};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            mem_r_q   <= 1'b0;
            mem_w_q   <= 1'b0;
            use_imm_q <= 1'b0;
            val1_q    <= '0;
            val2_q    <= '0;
            st_val_q  <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            dest_q    <= '0;
            cmd_q     <= '0;
        end else if (flush) begin
            valid_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            mem_r_q   <= 1'b0;
            mem_w_q   <= 1'b0;
            use_imm_q <= 1'b0;
            val1_q    <= '0;
            val2_q    <= '0;
            st_val_q  <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            dest_q    <= '0;
            cmd_q     <= '0;
        end else if (stall) begin
`ifdef ID_EXE_FORWARDING_EN
            val1_q    <= fwd_val1;
            val2_q    <= fwd_val2;
            st_val_q  <= fwd_st_val;
`endif
        end else begin
            valid_q   <= id_valid;
            wb_en_q   <= id_wb_en;
            mem_r_q   <= id_mem_r;
            mem_w_q   <= id_mem_w;
            use_imm_q <= id_use_imm;
            val1_q    <= id_val1;
            val2_q    <= id_use_imm ? id_imm : id_val2;
            st_val_q  <= id_st_val;
            rs1_q     <= id_rs1;
            rs2_q     <= id_rs2;
            dest_q    <= id_dest;
            cmd_q     <= id_exe_cmd;
        end
    end

    assign exe_valid  = valid_q;
    assign exe_wb_en  = valid_q & wb_en_q;
    assign exe_mem_r  = valid_q & mem_r_q;
    assign exe_mem_w  = valid_q & mem_w_q;
    assign exe_val1   = fwd_val1;
    assign exe_val2   = fwd_val2;
    assign exe_st_val = fwd_st_val;
    assign exe_cmd    = cmd_q;
    assign exe_dest   = dest_q;

endmodule

// File: tb/tb_id_exe_reg.sv
// tb_id_exe_reg: table-driven bench for id_exe_reg with an expectation queue.
// Expected outputs depend on whether ID_EXE_FORWARDING_EN is defined.

module tb_id_exe_reg;

`ifdef ID_EXE_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, id_valid, id_use_imm, id_wb_en, id_mem_r, id_mem_w;
    logic [31:0] id_val1, id_val2, id_st_val, id_imm, mem_result, wb_value;
    logic [4:0]  id_rs1, id_rs2, id_dest, mem_dest, wb_dest;
    logic [3:0]  id_exe_cmd;
    logic        mem_wb_en, wb_wb_en;
    logic        exe_valid, exe_wb_en, exe_mem_r, exe_mem_w;
    logic [31:0] exe_val1, exe_val2, exe_st_val;
    logic [3:0]  exe_cmd;
    logic [4:0]  exe_dest;

    id_exe_reg #(.WORD_LEN(32), .EXE_CMD_LEN(4), .REG_ADDR_LEN(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_val1(id_val1), .id_val2(id_val2), .id_st_val(id_st_val),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_dest(id_dest), .id_exe_cmd(id_exe_cmd), .id_wb_en(id_wb_en),
        .id_mem_r(id_mem_r), .id_mem_w(id_mem_w),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_result(mem_result),
        .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .exe_valid(exe_valid), .exe_wb_en(exe_wb_en), .exe_mem_r(exe_mem_r),
        .exe_mem_w(exe_mem_w), .exe_val1(exe_val1), .exe_val2(exe_val2),
        .exe_st_val(exe_st_val), .exe_cmd(exe_cmd), .exe_dest(exe_dest)
    );

    always #5 clk = ~clk;

    // ctl / e_ctl bit order: {valid, wb_en, mem_r, mem_w}
    typedef struct {
        logic        stall, flush;
        logic [3:0]  ctl;
        logic [31:0] v1, v2, st, imm;
        logic        use_imm;
        logic [4:0]  rs1, rs2, dest;
        logic [3:0]  cmd;
        logic        m_en;
        logic [4:0]  m_dest;
        logic [31:0] m_res;
        logic        w_en;
        logic [4:0]  w_dest;
        logic [31:0] w_val;
        logic [3:0]  e_ctl;
        logic [31:0] e_v1, e_v2, e_st;
        logic [3:0]  e_cmd;
        logic [4:0]  e_dest;
    } vec_t;

    vec_t exp_q[$];
    vec_t vecs[8];
    vec_t zv;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        stall      = v.stall;
        flush      = v.flush;
        {id_valid, id_wb_en, id_mem_r, id_mem_w} = v.ctl;
        id_val1    = v.v1;
        id_val2    = v.v2;
        id_st_val  = v.st;
        id_imm     = v.imm;
        id_use_imm = v.use_imm;
        id_rs1     = v.rs1;
        id_rs2     = v.rs2;
        id_dest    = v.dest;
        id_exe_cmd = v.cmd;
        mem_wb_en  = v.m_en;
        mem_dest   = v.m_dest;
        mem_result = v.m_res;
        wb_wb_en   = v.w_en;
        wb_dest    = v.w_dest;
        wb_value   = v.w_val;
    endtask

    task automatic compare_out(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: expectation queue empty", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".ctl"}, {28'd0, exe_valid, exe_wb_en, exe_mem_r, exe_mem_w},
                  {28'd0, e.e_ctl});
            check({tag, ".val1"}, exe_val1, e.e_v1);
            check({tag, ".val2"}, exe_val2, e.e_v2);
            check({tag, ".st_val"}, exe_st_val, e.e_st);
            check({tag, ".cmd"}, {28'd0, exe_cmd}, {28'd0, e.e_cmd});
            check({tag, ".dest"}, {27'd0, exe_dest}, {27'd0, e.e_dest});
        end
    endtask

    // Drive on the falling edge, compare just after the next rising edge.
    task automatic step(input string tag, input vec_t v);
        @(negedge clk);
        drive(v);
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    // Compare against all-zero outputs without waiting for an edge.
    task automatic check_zero(input string tag);
        exp_q.push_back(zv);
        #1;
        compare_out(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        zv = '{default: '0};

        vecs[0] = '{1'b0, 1'b0, 4'b1100, 32'd10, 32'd20, 32'd20, 32'd0, 1'b0,
                    5'd3, 5'd4, 5'd7, 4'd0,
                    1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                    4'b1100, 32'd10, 32'd20, 32'd20, 4'd0, 5'd7};
        vecs[1] = '{1'b0, 1'b0, 4'b1100, 32'd10, 32'd20, 32'd20, 32'd0, 1'b0,
                    5'd3, 5'd4, 5'd7, 4'd2,
                    1'b1, 5'd3, 32'h55, 1'b1, 5'd3, 32'h77,
                    4'b1100, FWD ? 32'h55 : 32'd10, 32'd20, 32'd20, 4'd2, 5'd7};
        vecs[2] = '{1'b0, 1'b0, 4'b1100, 32'd10, 32'd20, 32'd20, 32'd0, 1'b0,
                    5'd3, 5'd4, 5'd7, 4'd2,
                    1'b0, 5'd3, 32'h55, 1'b1, 5'd3, 32'h77,
                    4'b1100, FWD ? 32'h77 : 32'd10, 32'd20, 32'd20, 4'd2, 5'd7};
        vecs[3] = '{1'b0, 1'b0, 4'b1100, 32'd10, 32'd20, 32'd20, 32'd0, 1'b0,
                    5'd0, 5'd4, 5'd7, 4'd2,
                    1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h77,
                    4'b1100, 32'd10, 32'd20, 32'd20, 4'd2, 5'd7};
        vecs[4] = '{1'b0, 1'b0, 4'b1001, 32'd10, 32'd20, 32'h33, 32'hFFFF_FFF0, 1'b1,
                    5'd3, 5'd4, 5'd0, 4'd0,
                    1'b1, 5'd4, 32'h55, 1'b0, 5'd0, 32'd0,
                    4'b1001, 32'd10, 32'hFFFF_FFF0, FWD ? 32'h55 : 32'h33, 4'd0, 5'd0};
        vecs[5] = '{1'b0, 1'b0, 4'b1100, 32'd1, 32'd2, 32'd2, 32'd0, 1'b0,
                    5'd6, 5'd6, 5'd8, 4'd1,
                    1'b1, 5'd6, 32'hAA, 1'b1, 5'd6, 32'hBB,
                    4'b1100, FWD ? 32'hAA : 32'd1, FWD ? 32'hAA : 32'd2,
                    FWD ? 32'hAA : 32'd2, 4'd1, 5'd8};
        vecs[6] = '{1'b0, 1'b0, 4'b0111, 32'd5, 32'd6, 32'd7, 32'd0, 1'b0,
                    5'd1, 5'd2, 5'd9, 4'd5,
                    1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                    4'b0000, 32'd5, 32'd6, 32'd7, 4'd5, 5'd9};
        vecs[7] = '{1'b0, 1'b0, 4'b1110, 32'h100, 32'd4, 32'd0, 32'd4, 1'b1,
                    5'd2, 5'd0, 5'd11, 4'd3,
                    1'b1, 5'd2, 32'h1234, 1'b0, 5'd0, 32'd0,
                    4'b1110, FWD ? 32'h1234 : 32'h100, 32'd4, 32'd0, 4'd3, 5'd11};

        // Reset state
        drive(zv);
        rst_n = 1'b0;
        #3;
        check_zero("reset_init");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) step($sformatf("vec%0d", i), vecs[i]);

        // Two-cycle stall: WB supplies rs1=5 in the first cycle only.
        v = '{1'b0, 1'b0, 4'b1100, 32'h11, 32'h22, 32'h22, 32'd0, 1'b0,
              5'd5, 5'd8, 5'd2, 4'd1,
              1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
              4'b1100, 32'h11, 32'h22, 32'h22, 4'd1, 5'd2};
        step("stall_cap", v);
        v = '{1'b1, 1'b0, 4'b1011, 32'hDEAD, 32'hBEEF, 32'hCAFE, 32'd0, 1'b0,
              5'd9, 5'd9, 5'd4, 4'd7,
              1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h99,
              4'b1100, FWD ? 32'h99 : 32'h11, 32'h22, 32'h22, 4'd1, 5'd2};
        step("stall_c1", v);
        v.w_en = 1'b0;
        step("stall_c2", v);
        @(negedge clk);
        v.stall = 1'b0;
        drive(v);
        exp_q.push_back(v);
        #1;
        compare_out("stall_release");

        // Flush together with stall, then flush alone.
        v = '{1'b0, 1'b0, 4'b1101, 32'h1, 32'h2, 32'h3, 32'd0, 1'b0,
              5'd3, 5'd4, 5'd6, 4'd4,
              1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
              4'b1101, 32'h1, 32'h2, 32'h3, 4'd4, 5'd6};
        step("flush_cap", v);
        v.stall = 1'b1;
        v.flush = 1'b1;
        v.m_en = 1'b1; v.m_dest = 5'd3; v.m_res = 32'h55;
        v.w_en = 1'b1; v.w_dest = 5'd4; v.w_val = 32'h77;
        v.e_ctl = 4'b0000; v.e_v1 = 32'd0; v.e_v2 = 32'd0; v.e_st = 32'd0;
        v.e_cmd = 4'd0; v.e_dest = 5'd0;
        step("stall_flush", v);
        v.stall = 1'b0;
        step("flush_only", v);

        // Reset asserted mid-stall, between edges.
        v = '{1'b0, 1'b0, 4'b1100, 32'h44, 32'h45, 32'h46, 32'd0, 1'b0,
              5'd3, 5'd4, 5'd5, 4'd2,
              1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
              4'b1100, 32'h44, 32'h45, 32'h46, 4'd2, 5'd5};
        step("rst_cap", v);
        v.stall = 1'b1;
        step("rst_hold", v);
        #2;
        mem_wb_en = 1'b1; mem_dest = 5'd3; mem_result = 32'h55;
        rst_n = 1'b0;
        check_zero("rst_async");
        @(posedge clk);
        #1;
        check_zero("rst_edge");
        #2;
        rst_n = 1'b1;
        v.stall = 1'b0;
        v.v1 = 32'h60; v.e_v1 = 32'h60; v.e_dest = 5'd5;
        step("rst_first_cap", v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
